regfile_op_sequencer: RTL and testbench
=======================================

Name: regfile_op_sequencer

Overview:
Initiator side of the two-read/one-write register file port set. Accepts one instruction at a time over a valid/ready handshake, issues the operand reads, executes one of the 10 instruction-processor ops, and issues the writeback. It sits between the instruction decode stage and the register file. The register file samples all of its ports on negedge clk, and this block is the only master driving those ports.

Parameters:
DATA_WIDTH, 32, register and operand width
ADDRESS_WIDTH, 12, register index width
SHAMT_WIDTH, $clog2(DATA_WIDTH), number of src2 bits used as the shift amount

Ports:
clk  in  1  clock; all state updates on posedge clk
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instruction fields are valid
instr_ready  out  1  block can accept an instruction (high only in IDLE)
instr_op  in  4  opcode
instr_dst  in  ADDRESS_WIDTH  destination register
instr_src1  in  ADDRESS_WIDTH  source register 1
instr_src2  in  ADDRESS_WIDTH  source register 2
instr_imm  in  DATA_WIDTH  immediate value for LDI
rf_r_en_one / rf_r_en_two  out  1 each  register file read enables
rf_r_adrs_one / rf_r_adrs_two  out  ADDRESS_WIDTH each  register file read addresses
rf_r_data_one / rf_r_data_two  in  DATA_WIDTH each  register file read data, registered by the file on negedge
rf_w_en  out  1  register file write enable
rf_w_adrs  out  ADDRESS_WIDTH  register file write address
rf_w_data  out  DATA_WIDTH  register file write data
done_valid  out  1  one-cycle pulse: instruction retired
done_result  out  DATA_WIDTH  result of the last retired write op; holds between retirements
illegal_op  out  1  pulses together with done_valid when the opcode is 10-15
busy  out  1  state is not IDLE

Behaviour:
- Reset (sampled at posedge):
  - State goes to IDLE.
  - All rf_* outputs, done_valid, done_result, illegal_op and busy are 0.
  - instr_ready is 0 while reset is high.
  - Reset during any state abandons the instruction; no rf_w_en is issued afterwards.
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
  - 6 NOT: uses src1 only.
  - 7 SHL and 8 SHR: logical shifts of src1 by src2[SHAMT_WIDTH-1:0].
  - 9 LDI: dst <= instr_imm.
  - 10-15: illegal.
- Arithmetic: ADD and SUB wrap modulo 2^DATA_WIDTH; there is no carry or overflow output.
- States: IDLE, READ, EXEC, WRITE. All rf_* outputs are registered and stable for the whole cycle, so the register file's negedge samples them cleanly.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch op/dst/src1/src2/imm.
  - Ops 1-8 go to READ. Ops 0, 9 and illegal go directly to EXEC.
- READ (1 cycle):
  - rf_r_adrs_one=src1 and rf_r_en_one=1.
  - rf_r_adrs_two=src2 and rf_r_en_two=1, but only for ops 1-5, 7 and 8 (NOT leaves en_two=0).
  - The file captures the data at mid-cycle negedge, and it is valid at the next posedge. Go to EXEC.
- EXEC (1 cycle):
  - Compute the result from rf_r_data_one/two (or imm for LDI) into the result register.
  - Read enables are 0. Go to WRITE.
- WRITE (1 cycle):
  - Ops 1-9: rf_w_en=1, rf_w_adrs=dst, rf_w_data=result, done_result<=result.
  - NOP and illegal: rf_w_en=0 and done_result is unchanged.
  - done_valid=1. illegal_op=1 only for opcodes 10-15.
  - Return to IDLE.
- Latency, counting from the accepting posedge to the posedge that ends the WRITE cycle:
  - ALU ops: 3 cycles.
  - NOP, LDI and illegal: 2 cycles.
  - instr_ready is high again in the following cycle, so throughput is 1 instruction per 4 cycles (3 for the short ops).
- Hazards:
  - A write lands at the negedge inside WRITE, and the next instruction's READ is at least 2 cycles later, so read-after-write needs no forwarding.
  - Writing to the same register that was read (e.g. dst==src1) is legal.
- rf_w_data outside WRITE is don't-care; drive 0.
- instr_* fields are ignored when instr_ready=0.

Test Plan:
1. Reset high 2 cycles, then low → instr_ready=1 next cycle; all rf_* outputs, done_valid and illegal_op are 0.
2. LDI dst=3 imm=0x0000_0005, then LDI dst=4 imm=0xFFFF_FFFF, then ADD dst=5 src1=3 src2=4 →
   - reg5=0x0000_0004 with wrap.
   - done_result=0x4 and done_valid pulses exactly once per instruction.
   - ADD is 3 cycles from accept to end of WRITE.
3. SHL dst=6 src1=3 src2=7 with reg3=5, reg7=0x21 → shift amount 1, reg6=0xA. Then SHR dst=6 src1=6 src2=7 → reg6=0x5.
4. NOT dst=8 src1=3 (reg3=5) → rf_r_en_two stays 0, reg8=0xFFFF_FFFA. Then opcode 12 → done_valid=1, illegal_op=1, rf_w_en=0, done_result still 0xFFFF_FFFA.
5. Accept ADD, assert reset during EXEC → no rf_w_en ever pulses for that ADD; instr_ready=1 in the cycle after reset deasserts.
6. Hold instr_valid high with back-to-back LDI r1=1 then ADD r1=r1+r1, repeated 4 times → accepts only in IDLE, and r1 goes 2, 4, 8, 16 with no lost or duplicated writes.

Source files
------------

// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: initiator for a two-read/one-write register file.
// Accepts one instruction over valid/ready, reads operands, executes one of
// ten ops and writes the result back. Every output is registered so the
// register file's negedge sampling always sees stable values.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instr_valid/instr_ready    instruction handshake (ready only in IDLE)
//   instr_op/dst/src1/src2/imm instruction fields
//   rf_r_en_*/rf_r_adrs_*      operand read requests
//   rf_r_data_*                operand data, registered by the file on negedge
//   rf_w_en/rf_w_adrs/rf_w_data writeback request
//   done_valid/done_result     retirement pulse and last written result
//   illegal_op                 retirement of an opcode in 10..15
//   busy                       not IDLE
module regfile_op_sequencer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned SHAMT_WIDTH   = $clog2(DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [3:0]               instr_op,
  input  logic [ADDRESS_WIDTH-1:0] instr_dst,
  input  logic [ADDRESS_WIDTH-1:0] instr_src1,
  input  logic [ADDRESS_WIDTH-1:0] instr_src2,
  input  logic [DATA_WIDTH-1:0]    instr_imm,
  output logic                     rf_r_en_one,
  output logic                     rf_r_en_two,
  output logic [ADDRESS_WIDTH-1:0] rf_r_adrs_one,
  output logic [ADDRESS_WIDTH-1:0] rf_r_adrs_two,
  input  logic [DATA_WIDTH-1:0]    rf_r_data_one,
  input  logic [DATA_WIDTH-1:0]    rf_r_data_two,
  output logic                     rf_w_en,
  output logic [ADDRESS_WIDTH-1:0] rf_w_adrs,
  output logic [DATA_WIDTH-1:0]    rf_w_data,
  output logic                     done_valid,
  output logic [DATA_WIDTH-1:0]    done_result,
  output logic                     illegal_op,
  output logic                     busy
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_LDI = 4'd9;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t state, state_next;

  logic [3:0]               op_q;
  logic [ADDRESS_WIDTH-1:0] dst_q;
  logic [DATA_WIDTH-1:0]    imm_q;

  logic                     accept_c;
  logic                     new_reads_c, new_uses_two_c, cur_writes_c;
  logic [SHAMT_WIDTH-1:0]   shamt_c;
  logic [DATA_WIDTH-1:0]    alu_result_c;

  logic                     instr_ready_next, busy_next;
  logic                     r_en_one_next, r_en_two_next;
  logic [ADDRESS_WIDTH-1:0] r_adrs_one_next, r_adrs_two_next;
  logic                     w_en_next;
  logic [ADDRESS_WIDTH-1:0] w_adrs_next;
  logic [DATA_WIDTH-1:0]    w_data_next, done_result_next;
  logic                     done_valid_next, illegal_next;

  assign accept_c       = instr_valid && instr_ready && (state == IDLE);
  assign new_reads_c    = (instr_op >= OP_ADD) && (instr_op <= OP_SHR);
  assign new_uses_two_c = new_reads_c && (instr_op != OP_NOT);
  assign cur_writes_c   = (op_q >= OP_ADD) && (op_q <= OP_LDI);
  assign shamt_c        = rf_r_data_two[SHAMT_WIDTH-1:0];

  // Operation result, evaluated in EXEC while the file's read data is valid.
  always_comb begin
    alu_result_c = '0;
    case (op_q)
      OP_ADD:  alu_result_c = rf_r_data_one + rf_r_data_two;
      OP_SUB:  alu_result_c = rf_r_data_one - rf_r_data_two;
      OP_AND:  alu_result_c = rf_r_data_one & rf_r_data_two;
      OP_OR:   alu_result_c = rf_r_data_one | rf_r_data_two;
      OP_XOR:  alu_result_c = rf_r_data_one ^ rf_r_data_two;
      OP_NOT:  alu_result_c = ~rf_r_data_one;
      OP_SHL:  alu_result_c = rf_r_data_one << shamt_c;
      OP_SHR:  alu_result_c = rf_r_data_one >> shamt_c;
      OP_LDI:  alu_result_c = imm_q;
      default: alu_result_c = '0;
    endcase
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_next       = state;
    r_en_one_next    = 1'b0;
    r_en_two_next    = 1'b0;
    r_adrs_one_next  = '0;
    r_adrs_two_next  = '0;
    w_en_next        = 1'b0;
    w_adrs_next      = '0;
    w_data_next      = '0;
    done_valid_next  = 1'b0;
    illegal_next     = 1'b0;
    done_result_next = done_result;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (new_reads_c) begin
            state_next      = READ;
            r_en_one_next   = 1'b1;
            r_adrs_one_next = instr_src1;
            if (new_uses_two_c) begin
              r_en_two_next   = 1'b1;
              r_adrs_two_next = instr_src2;
            end
          end else begin
            state_next = EXEC;
          end
        end
      end
      READ: state_next = EXEC;
      EXEC: begin
        state_next      = WRITE;
        done_valid_next = 1'b1;
        illegal_next    = (op_q > OP_LDI);
        if (cur_writes_c) begin
          w_en_next        = 1'b1;
          w_adrs_next      = dst_q;
          w_data_next      = alu_result_c;
          done_result_next = alu_result_c;
        end
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    instr_ready_next = (state_next == IDLE);
    busy_next        = (state_next != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      instr_ready   <= 1'b0;
      busy          <= 1'b0;
      rf_r_en_one   <= 1'b0;
      rf_r_en_two   <= 1'b0;
      rf_r_adrs_one <= '0;
      rf_r_adrs_two <= '0;
      rf_w_en       <= 1'b0;
      rf_w_adrs     <= '0;
      rf_w_data     <= '0;
      done_valid    <= 1'b0;
      illegal_op    <= 1'b0;
      done_result   <= '0;
    end else begin
      state         <= state_next;
      instr_ready   <= instr_ready_next;
      busy          <= busy_next;
      rf_r_en_one   <= r_en_one_next;
      rf_r_en_two   <= r_en_two_next;
      rf_r_adrs_one <= r_adrs_one_next;
      rf_r_adrs_two <= r_adrs_two_next;
      rf_w_en       <= w_en_next;
      rf_w_adrs     <= w_adrs_next;
      rf_w_data     <= w_data_next;
      done_valid    <= done_valid_next;
      illegal_op    <= illegal_next;
      done_result   <= done_result_next;
    end
  end

  // Instruction fields still needed after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= '0;
      dst_q <= '0;
      imm_q <= '0;
    end else if (accept_c) begin
      op_q  <= instr_op;
      dst_q <= instr_dst;
      imm_q <= instr_imm;
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: models the register file (negedge sampling)
// and predicts every retirement from an architectural register model.
module tb_regfile_op_sequencer;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid, instr_ready;
  logic [3:0]    instr_op;
  logic [AW-1:0] instr_dst, instr_src1, instr_src2;
  logic [DW-1:0] instr_imm;
  logic          rf_r_en_one, rf_r_en_two;
  logic [AW-1:0] rf_r_adrs_one, rf_r_adrs_two;
  logic [DW-1:0] rf_r_data_one, rf_r_data_two;
  logic          rf_w_en;
  logic [AW-1:0] rf_w_adrs;
  logic [DW-1:0] rf_w_data;
  logic          done_valid;
  logic [DW-1:0] done_result;
  logic          illegal_op, busy;

  logic [DW-1:0] rf_mem    [0:(1<<AW)-1];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];

  int passed = 0, total = 0;
  int wr_count = 0, done_count = 0, accept_count = 0;
  int exp_writes = 0, exp_dones = 0, exp_accepts = 0;
  logic [DW-1:0] exp_done = '0;

  always #5 clk = ~clk;

  regfile_op_sequencer dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_dst(instr_dst),
    .instr_src1(instr_src1), .instr_src2(instr_src2), .instr_imm(instr_imm),
    .rf_r_en_one(rf_r_en_one), .rf_r_en_two(rf_r_en_two),
    .rf_r_adrs_one(rf_r_adrs_one), .rf_r_adrs_two(rf_r_adrs_two),
    .rf_r_data_one(rf_r_data_one), .rf_r_data_two(rf_r_data_two),
    .rf_w_en(rf_w_en), .rf_w_adrs(rf_w_adrs), .rf_w_data(rf_w_data),
    .done_valid(done_valid), .done_result(done_result),
    .illegal_op(illegal_op), .busy(busy)
  );

  // Register file: samples requests on negedge, read data registered.
  always @(negedge clk) begin
    if (rf_r_en_one) rf_r_data_one <= rf_mem[rf_r_adrs_one];
    if (rf_r_en_two) rf_r_data_two <= rf_mem[rf_r_adrs_two];
    if (rf_w_en) begin
      rf_mem[rf_w_adrs] <= rf_w_data;
      wr_count++;
    end
    if (done_valid) done_count++;
  end

  always @(posedge clk) begin
    if (!reset && instr_valid && instr_ready) accept_count++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Architectural result of an op, from plain modular arithmetic.
  function automatic logic [DW-1:0] ref_result(input logic [3:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b, input logic [DW-1:0] imm);
    logic [63:0] modulus, wide;
    int unsigned sh;
    modulus = 64'h1_0000_0000;
    sh = b % 32;
    case (op)
      4'd1: wide = (64'(a) + 64'(b)) % modulus;
      4'd2: wide = (64'(a) + modulus - 64'(b)) % modulus;
      4'd3: wide = 64'(a & b);
      4'd4: wide = 64'(a | b);
      4'd5: wide = 64'(a ^ b);
      4'd6: wide = 64'(~a);
      4'd7: wide = (64'(a) << sh) % modulus;
      4'd8: wide = 64'(a) >> sh;
      4'd9: wide = 64'(imm);
      default: wide = '0;
    endcase
    return wide[DW-1:0];
  endfunction

  // Issue one instruction and check its whole lifetime up to the cycle after WRITE.
  task automatic run_instr(input logic [3:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] s1,
                           input logic [AW-1:0] s2, input logic [DW-1:0] imm, input bit hold);
    int waited, cyc;
    bit alu, two, wr;
    logic [DW-1:0] exp_res;
    alu = (op >= 4'd1) && (op <= 4'd8);
    two = alu && (op != 4'd6);
    wr  = (op >= 4'd1) && (op <= 4'd9);
    exp_res = ref_result(op, model_mem[s1], model_mem[s2], imm);
    instr_op = op; instr_dst = dst; instr_src1 = s1; instr_src2 = s2; instr_imm = imm;
    instr_valid = 1'b1;
    waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      check("accept_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;
    exp_accepts++;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("rd_en_one", 32'(rf_r_en_one), 32'(alu));
        check("rd_en_two", 32'(rf_r_en_two), 32'(two));
        if (alu) check("rd_adrs_one", 32'(rf_r_adrs_one), 32'(s1));
        if (two) check("rd_adrs_two", 32'(rf_r_adrs_two), 32'(s2));
      end
    end while (!done_valid && cyc < 10);
    check("latency", 32'(cyc), alu ? 32'd3 : 32'd2);
    check("done_valid", 32'(done_valid), 32'd1);
    check("illegal_op", 32'(illegal_op), 32'(op >= 4'd10));
    check("wr_en", 32'(rf_w_en), 32'(wr));
    if (wr) begin
      check("wr_adrs", 32'(rf_w_adrs), 32'(dst));
      check("wr_data", rf_w_data, exp_res);
      exp_done = exp_res;
      model_mem[dst] = exp_res;
      exp_writes++;
    end
    check("done_result", done_result, exp_done);
    exp_dones++;
    @(negedge clk);
    check("done_pulse_end", 32'(done_valid), 32'd0);
    check("ready_after", 32'(instr_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr_op = '0; instr_dst = '0; instr_src1 = '0; instr_src2 = '0; instr_imm = '0;

    // Reset and its output values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rf", 32'({rf_r_en_one, rf_r_en_two, rf_w_en}), 32'd0);
    check("rst_adrs", 32'(rf_r_adrs_one | rf_r_adrs_two | rf_w_adrs), 32'd0);
    check("rst_wdata", rf_w_data, 32'd0);
    check("rst_done", 32'({done_valid, illegal_op}), 32'd0);
    check("rst_result", done_result, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(instr_ready), 32'd1);
    check("post_rst_rf", 32'({rf_r_en_one, rf_r_en_two, rf_w_en, done_valid, illegal_op}), 32'd0);

    // LDI, LDI, wrapping ADD.
    run_instr(4'd9, 12'd3, 12'd0, 12'd0, 32'h0000_0005, 1'b0);
    run_instr(4'd9, 12'd4, 12'd0, 12'd0, 32'hFFFF_FFFF, 1'b0);
    run_instr(4'd1, 12'd5, 12'd3, 12'd4, 32'h0, 1'b0);
    check("reg5", rf_mem[5], 32'h0000_0004);
    check("add_done_result", done_result, 32'h0000_0004);

    // Shifts use only the low shamt bits of src2.
    run_instr(4'd9, 12'd7, 12'd0, 12'd0, 32'h0000_0021, 1'b0);
    run_instr(4'd7, 12'd6, 12'd3, 12'd7, 32'h0, 1'b0);
    check("reg6_shl", rf_mem[6], 32'h0000_000A);
    run_instr(4'd8, 12'd6, 12'd6, 12'd7, 32'h0, 1'b0);
    check("reg6_shr", rf_mem[6], 32'h0000_0005);

    // NOT, then an illegal opcode that must not write.
    run_instr(4'd6, 12'd8, 12'd3, 12'd9, 32'h0, 1'b0);
    check("reg8_not", rf_mem[8], 32'hFFFF_FFFA);
    run_instr(4'd12, 12'd8, 12'd0, 12'd0, 32'h1234, 1'b0);
    check("illegal_keeps_result", done_result, 32'hFFFF_FFFA);
    check("illegal_no_write", rf_mem[8], 32'hFFFF_FFFA);

    // Reset during EXEC abandons the ADD.
    instr_op = 4'd1; instr_dst = 12'd9; instr_src1 = 12'd3; instr_src2 = 12'd4; instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    exp_accepts++;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_exec", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_no_write", 32'(rf_w_en), 32'd0);
    check("abort_no_done", 32'(done_valid), 32'd0);
    check("abort_ready_in_rst", 32'(instr_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 32'(instr_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("abort_write_count", 32'(wr_count), 32'(exp_writes));
    exp_done = '0;

    // instr_valid held high across back-to-back instructions.
    run_instr(4'd9, 12'd1, 12'd0, 12'd0, 32'd1, 1'b1);
    for (int i = 0; i < 4; i++) run_instr(4'd1, 12'd1, 12'd1, 12'd1, 32'd0, 1'b1);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("r1_final", rf_mem[1], 32'd16);
    check("hold_write_count", 32'(wr_count), 32'(exp_writes));
    check("hold_accept_count", 32'(accept_count), 32'(exp_accepts));

    // Randomized instructions against the register model.
    for (int r = 0; r < 16; r++) run_instr(4'd9, 12'(r), 12'd0, 12'd0, $urandom, 1'b0);
    for (int n = 0; n < 40; n++) begin
      run_instr(4'($urandom_range(0, 15)), 12'($urandom_range(0, 15)), 12'($urandom_range(0, 15)),
                12'($urandom_range(0, 15)), $urandom, 1'b0);
    end
    for (int r = 0; r < 16; r++) check("final_reg", rf_mem[r], model_mem[r]);
    check("total_writes", 32'(wr_count), 32'(exp_writes));
    check("total_dones", 32'(done_count), 32'(exp_dones));
    check("total_accepts", 32'(accept_count), 32'(exp_accepts));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
